gauss_node_mc: RTL and testbench



---
 rtl/gauss_node_mc_pkg.sv | 35 +++
 rtl/gauss_node_mc_if.sv | 15 +
 rtl/gauss_node_mc_lane.sv | 19 +
 rtl/gauss_node_mc.sv | 86 ++++++++
 tb/tb_gauss_node_mc.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/gauss_node_mc_pkg.sv
// gauss_node_mc_pkg: op codes, lane result record and the single-lane GF(2) pass/swap/add rule.
package gauss_node_mc_pkg;

    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_SWAP = 2'b01,
        OP_ADD  = 2'b10,
        OP_NOP  = 2'b11
    } op_t;

    typedef struct packed {
        logic r_nxt;
        logic dout;
        op_t  op;
        logic pivot;
    } lane_res_t;

    function automatic lane_res_t lane_step(input logic start, input logic d, input op_t op,
                                            input logic pivot, input logic r);
        lane_res_t s;
        s = '{r_nxt: r, dout: d, op: op, pivot: 1'b1};
        if (start)
            s = '{r_nxt: d, dout: 1'b0, op: OP_SWAP, pivot: pivot | d};
        else if (!pivot && r)
            s = '{r_nxt: r, dout: 1'b0, op: d ? OP_ADD : OP_PASS, pivot: 1'b1};
        else if (!pivot)
            s = '{r_nxt: d, dout: r, op: OP_SWAP, pivot: d};
        else if (op == OP_SWAP)
            s = '{r_nxt: d, dout: r, op: op, pivot: 1'b1};
        else if (op == OP_ADD)
            s.dout = d ^ r;
        return s;
    endfunction

endpackage

// File: rtl/gauss_node_mc_if.sv
// gauss_node_mc_if: one systolic beat (context tag, phase, lane data/ops/pivots) between cells.
interface gauss_node_mc_if #(
    parameter int W   = 8,
    parameter int CHW = 2
);
    logic           valid;
    logic [CHW-1:0] ch;
    logic           start;
    logic [W-1:0]   data;
    logic [2*W-1:0] op;
    logic [W-1:0]   pivot;

    modport master(output valid, ch, start, data, op, pivot);
    modport slave(input valid, ch, start, data, op, pivot);
endinterface

// File: rtl/gauss_node_mc_lane.sv
// gauss_node_mc_lane: combinational next-state and outputs for one bit-sliced lane.
module gauss_node_mc_lane
    import gauss_node_mc_pkg::*;
(
    input  logic       start,
    input  logic       d,
    input  logic [1:0] op_in,
    input  logic       pivot_in,
    input  logic       r,
    output logic       r_nxt,
    output logic       dout,
    output logic [1:0] op_out,
    output logic       pivot_out
);
    lane_res_t s;

    assign s = lane_step(start, d, op_t'(op_in), pivot_in, r);
    assign {r_nxt, dout, op_out, pivot_out} = s;
endmodule

// File: rtl/gauss_node_mc.sv
// gauss_node_mc: multi-context, W-lane GF(2) elimination cell with per-context row counters,
// clear and readback; all beat outputs are registered one cycle after acceptance.
module gauss_node_mc
    import gauss_node_mc_pkg::*;
#(
    parameter int W     = 8,
    parameter int CH    = 4,
    parameter int N     = 16,
    localparam int CHW  = (CH > 1) ? $clog2(CH) : 1,
    localparam int CNTW = $clog2(N + 1)
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   en,
    gauss_node_mc_if.slave         up,
    gauss_node_mc_if.master        dn,
    input  logic                   clr_in,
    input  logic [CHW-1:0]         clr_ch,
    input  logic [CHW-1:0]         rd_ch,
    output logic                   done_out,
    output logic [W-1:0]           rd_r
);
    localparam logic [CNTW-1:0] NMAX = CNTW'(N);

    logic [W-1:0]    r_q   [CH];
    logic [CNTW-1:0] cnt_q [CH];
    logic [W-1:0]    r_cur, r_nxt, dout, pvt;
    logic [2*W-1:0]  op;
    logic [CNTW-1:0] cnt_cur, cnt_nxt;
    logic            sat, done;

    assign r_cur   = r_q[up.ch];
    assign cnt_cur = cnt_q[up.ch];
    assign sat     = cnt_cur == NMAX;
    assign cnt_nxt = up.start ? '0 : sat ? cnt_cur : cnt_cur + CNTW'(1);
    assign done    = !up.start && cnt_cur == NMAX - CNTW'(1);

    for (genvar i = 0; i < W; i++) begin : g_lane
        gauss_node_mc_lane u_lane (
            .start    (up.start),
            .d        (up.data[i]),
            .op_in    (up.op[2*i +: 2]),
            .pivot_in (up.pivot[i]),
            .r        (r_cur[i]),
            .r_nxt    (r_nxt[i]),
            .dout     (dout[i]),
            .op_out   (op[2*i +: 2]),
            .pivot_out(pvt[i])
        );
    end

    // A clear on the beat's own context overrides the beat's state write.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int c = 0; c < CH; c++) begin
                r_q[c]   <= '0;
                cnt_q[c] <= '0;
            end
            dn.valid <= 1'b0;
            dn.ch    <= '0;
            dn.start <= 1'b0;
            dn.data  <= '0;
            dn.op    <= '0;
            dn.pivot <= '0;
            done_out <= 1'b0;
            rd_r     <= '0;
        end else if (en) begin
            if (up.valid) begin
                r_q[up.ch]   <= r_nxt;
                cnt_q[up.ch] <= cnt_nxt;
            end
            if (clr_in) begin
                r_q[clr_ch]   <= '0;
                cnt_q[clr_ch] <= '0;
            end
            dn.valid <= up.valid;
            dn.ch    <= up.ch;
            dn.start <= up.start;
            dn.data  <= up.valid ? dout : '0;
            dn.op    <= up.valid ? op : '0;
            dn.pivot <= up.valid ? pvt : '0;
            done_out <= up.valid && done;
            rd_r     <= r_q[rd_ch];
        end
    end
endmodule

// File: tb/tb_gauss_node_mc.sv
// tb_gauss_node_mc: hand-derived vector table and corner sequences checked through an expectation queue.
module tb_gauss_node_mc;
    localparam int W = 4, CH = 2, N = 3, CHW = 1;

    logic           clk = 1'b0;
    logic           rst_b = 1'b1;
    logic           en = 1'b0;
    logic           clr_in = 1'b0;
    logic [CHW-1:0] clr_ch = '0;
    logic [CHW-1:0] rd_ch = '0;
    logic           done_out;
    logic [W-1:0]   rd_r;

    gauss_node_mc_if #(.W(W), .CHW(CHW)) up ();
    gauss_node_mc_if #(.W(W), .CHW(CHW)) dn ();

    gauss_node_mc #(.W(W), .CH(CH), .N(N)) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .en      (en),
        .up      (up),
        .dn      (dn),
        .clr_in  (clr_in),
        .clr_ch  (clr_ch),
        .rd_ch   (rd_ch),
        .done_out(done_out),
        .rd_r    (rd_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v, ch, st;
        logic [3:0] d;
        logic [7:0] op;
        logic [3:0] pv;
        logic       done;
        logic [3:0] rd;
    } beat_t;

    typedef struct {
        logic       v, st, ch;
        logic [3:0] d;
        logic [7:0] op;
        logic [3:0] pv;
        logic       clr, cc, rc;
        logic [3:0] ed;
        logic [7:0] eop;
        logic [3:0] epv;
        logic       edone;
        logic [3:0] erd;
    } vec_t;

    vec_t  tbl [19];
    beat_t q[$];
    beat_t last;
    int    tests = 0, fails = 0;

    task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h, want %h", nm, a, e);
        end
    endtask

    task automatic drive(input logic v, input logic st, input logic ch, input logic [3:0] d,
                         input logic [7:0] op, input logic [3:0] pv,
                         input logic c, input logic cc, input logic rc);
        up.valid = v; up.start = st; up.ch = ch; up.data = d; up.op = op; up.pivot = pv;
        clr_in = c; clr_ch = cc; rd_ch = rc;
    endtask

    task automatic expect_beat(input logic v, input logic st, input logic ch, input logic [3:0] d,
                               input logic [7:0] op, input logic [3:0] pv,
                               input logic done, input logic [3:0] rd);
        beat_t e;
        e = '{v: v, ch: ch, st: st, d: d, op: op, pv: pv, done: done, rd: rd};
        q.push_back(e);
        last = e;
    endtask

    task automatic check_outs(input string nm, input beat_t e);
        chk({nm, " valid"}, 8'(dn.valid), 8'(e.v));
        chk({nm, " ch"},    8'(dn.ch),    8'(e.ch));
        chk({nm, " start"}, 8'(dn.start), 8'(e.st));
        chk({nm, " data"},  8'(dn.data),  8'(e.d));
        chk({nm, " op"},    dn.op,        e.op);
        chk({nm, " pivot"}, 8'(dn.pivot), 8'(e.pv));
        chk({nm, " done"},  8'(done_out), 8'(e.done));
        chk({nm, " rd_r"},  8'(rd_r),     8'(e.rd));
    endtask

    task automatic tick(input string nm);
        beat_t e;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: no expectation queued", nm);
        end else begin
            e = q.pop_front();
            check_outs(nm, e);
        end
    endtask

    initial begin
        beat_t z;
        z = '{v: 1'b0, ch: 1'b0, st: 1'b0, d: 4'h0, op: 8'h00, pv: 4'h0, done: 1'b0, rd: 4'h0};
        //         v     st    ch    d        op           pv       clr   cc    rc    ed       eop          epv      done  rd
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 4'b1010, 8'h00,       4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 8'b01010101, 4'b1010, 1'b0, 4'b0000};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 8'h00,       4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00,       4'b0000, 1'b0, 4'b1010};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 4'b1100, 8'h00,       4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 8'b10010001, 4'b1110, 1'b0, 4'b1010};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 4'b0001, 8'h00,       4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 8'b01010101, 4'b0001, 1'b0, 4'b1110};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 4'b0110, 8'b00011011, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0100, 8'b00011011, 4'b1111, 1'b0, 4'b0001};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 4'b0011, 8'h00,       4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 8'b00001001, 4'b1111, 1'b1, 4'b1110};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 8'h00,       4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00,       4'b1111, 1'b0, 4'b1111};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 4'b1000, 8'h00,       4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 8'b01010100, 4'b1001, 1'b0, 4'b0001};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 4'b1111, 8'b01010101, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b1001, 8'b01010101, 4'b1111, 1'b0, 4'b1001};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 4'b0101, 8'h00,       4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 8'b00100010, 4'b1111, 1'b0, 4'b1111};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 4'b0000, 8'h00,       4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00,       4'b0000, 1'b0, 4'b0000};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 4'b1010, 8'b10101010, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b1010, 8'b10101010, 4'b1111, 1'b0, 4'b0000};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 4'b0000, 8'hFF,       4'b1111, 1'b0, 1'b0, 1'b1, 4'b0000, 8'hFF,       4'b1111, 1'b1, 4'b1111};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 4'b0000, 8'h00,       4'b0000, 1'b1, 1'b1, 1'b1, 4'b0000, 8'h00,       4'b0000, 1'b0, 4'b1111};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 4'b0000, 8'h00,       4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 8'h00,       4'b0000, 1'b0, 4'b0000};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 4'b0011, 8'h00,       4'b0101, 1'b0, 1'b0, 1'b0, 4'b0000, 8'b01010101, 4'b0111, 1'b0, 4'b0000};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 4'b0000, 8'h00,       4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 8'b01010000, 4'b0011, 1'b0, 4'b0011};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 4'b0000, 8'h00,       4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 8'b01010000, 4'b0011, 1'b0, 4'b0011};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 4'b0000, 8'h00,       4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 8'b01010000, 4'b0011, 1'b1, 4'b0011};

        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
        rst_b = 1'b0;
        #2;
        check_outs("reset", z);
        rst_b = 1'b1;
        en = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].v, tbl[i].st, tbl[i].ch, tbl[i].d, tbl[i].op, tbl[i].pv,
                  tbl[i].clr, tbl[i].cc, tbl[i].rc);
            expect_beat(tbl[i].v, tbl[i].st, tbl[i].ch, tbl[i].ed, tbl[i].eop, tbl[i].epv,
                        tbl[i].edone, tbl[i].erd);
            tick($sformatf("vec%0d", i));
        end

        // Frozen pipeline: a conflicting beat and clear must be ignored, outputs held.
        en = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 4'hF, 8'h00, 4'hF, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            q.push_back(last);
            tick($sformatf("hold%0d", i));
        end
        en = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
        expect_beat(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 4'h0, 1'b0, 4'b0011);
        tick("unfreeze");
        drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
        expect_beat(1'b1, 1'b0, 1'b0, 4'h0, 8'b01010000, 4'b0011, 1'b0, 4'b0011);
        tick("post_hold_sat");

        // Asynchronous reset in the middle of a pending beat.
        drive(1'b1, 1'b0, 1'b1, 4'hF, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_b = 1'b0;
        #1;
        check_outs("async_rst", z);
        #2;
        rst_b = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1);
        expect_beat(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 4'h0, 1'b0, 4'h0);
        tick("rst_rd1");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
            expect_beat(1'b1, 1'b0, 1'b0, 4'h0, 8'b01010101, 4'h0, i == 2, 4'h0);
            tick($sformatf("rst_cnt%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
